// File: rtl/motion_pkg.sv
// Shared motion-mode codes, encoder FSM states and the wheel-command layout.
package motion_pkg;

    localparam int unsigned MOTCTL_W  = 8;
    localparam int unsigned MODE_W    = 3;
    localparam int unsigned CHG_CNT_W = 8;
    localparam int unsigned QCNT_W    = 4;
    localparam int unsigned STALE_W   = 26;

    typedef enum logic [MODE_W-1:0] {
        MODE_STOP     = 3'b000,
        MODE_RIGHT_1X = 3'b001,
        MODE_RIGHT_2X = 3'b010,
        MODE_LEFT_1X  = 3'b011,
        MODE_LEFT_2X  = 3'b100,
        MODE_FORWARD  = 3'b101,
        MODE_REVERSE  = 3'b110
    } motion_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_QUALIFY = 2'd1,
        ST_LOCKED  = 2'd2
    } enc_state_e;

    typedef struct packed {
        logic       l_dir;
        logic [2:0] l_spd;
        logic       r_dir;
        logic [2:0] r_spd;
    } motctl_t;

    // Signed wheel velocity: direction bit set means forward; zero speed is zero either way.
    function automatic logic signed [3:0] wheel_vel(input logic dir, input logic [2:0] spd);
        logic signed [3:0] mag;
        mag = $signed({1'b0, spd});
        return dir ? mag : -mag;
    endfunction

endpackage

// File: rtl/motion_mode_encoder_if.sv
// Sample-strobe command input and committed-mode outputs of the motion mode encoder.
interface motion_mode_encoder_if;
    import motion_pkg::*;

    logic [MOTCTL_W-1:0]  motctl;
    logic                 upd_sysregs;
    logic [MODE_W-1:0]    motion_mode;
    logic                 mode_valid;
    logic                 mode_changed;
    logic [CHG_CNT_W-1:0] change_count;

    modport master (
        output motctl, upd_sysregs,
        input  motion_mode, mode_valid, mode_changed, change_count
    );

    modport slave (
        input  motctl, upd_sysregs,
        output motion_mode, mode_valid, mode_changed, change_count
    );

endinterface

// File: rtl/motion_classify.sv
// Combinational classifier: wheel command to motion mode class.
module motion_classify
    import motion_pkg::*;
(
    input  logic [MOTCTL_W-1:0] motctl,
    output motion_mode_e        mode_class
);

    motctl_t           cmd;
    logic signed [3:0] vl;
    logic signed [3:0] vr;

    always_comb begin
        cmd = motctl_t'(motctl);
        vl  = wheel_vel(cmd.l_dir, cmd.l_spd);
        vr  = wheel_vel(cmd.r_dir, cmd.r_spd);
        mode_class = MODE_LEFT_1X;
        if (vl == 4'sd0 && vr == 4'sd0)       mode_class = MODE_STOP;
        else if (vl == vr && vl > 4'sd0)      mode_class = MODE_FORWARD;
        else if (vl == vr && vl < 4'sd0)      mode_class = MODE_REVERSE;
        else if (vl > 4'sd0 && vr < 4'sd0)    mode_class = MODE_RIGHT_2X;
        else if (vl < 4'sd0 && vr > 4'sd0)    mode_class = MODE_LEFT_2X;
        else if (vl > vr)                     mode_class = MODE_RIGHT_1X;
    end

endmodule

// File: rtl/motion_mode_encoder.sv
// Debounced motion-mode encoder with stale-sample timeout.
// Optional MOTION_CHANGE_CNT_EN adds a saturating commit counter on change_count.
module motion_mode_encoder
    import motion_pkg::*;
#(
    parameter int unsigned         STABLE_CNT   = 3,
    parameter logic [STALE_W-1:0]  STALE_CYCLES = 26'd49_999_999
) (
    input  logic                  clk,
    input  logic                  reset,
    motion_mode_encoder_if.slave  bus
);

    localparam logic [QCNT_W-1:0]  STABLE_Q   = QCNT_W'(STABLE_CNT);
    localparam logic [STALE_W-1:0] STALE_TERM = STALE_CYCLES - STALE_W'(1);
    localparam bit                 ONE_SHOT   = (STABLE_CNT == 1);

    enc_state_e          state_q, state_d;
    motion_mode_e        cls;
    motion_mode_e        cand_q, cand_d;
    motion_mode_e        mode_q, mode_d;
    logic [QCNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [STALE_W-1:0]  stale_q;
    logic                valid_q, valid_d;
    logic                changed_q, changed_d;
    logic                commit;
    logic                strobe;
    logic                timeout;

    motion_classify u_classify (
        .motctl     (bus.motctl),
        .mode_class (cls)
    );

    assign strobe  = bus.upd_sysregs;
    assign timeout = !strobe && (stale_q == STALE_TERM);
    assign cnt_inc = cnt_q + QCNT_W'(1);

    // Idle-clock counter; parks at the terminal value so a timeout fires once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                        stale_q <= '0;
        else if (strobe)                  stale_q <= '0;
        else if (stale_q != STALE_CYCLES) stale_q <= stale_q + STALE_W'(1);
    end

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        valid_d   = valid_q;
        changed_d = 1'b0;
        commit    = 1'b0;
        if (timeout) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            mode_d  = MODE_STOP;
            cnt_d   = '0;
        end else if (strobe) begin
            unique case (state_q)
                ST_IDLE: begin
                    cand_d  = cls;
                    cnt_d   = QCNT_W'(1);
                    commit  = ONE_SHOT;
                    state_d = ST_QUALIFY;
                end
                ST_QUALIFY: begin
                    if (cls == cand_q) begin
                        cnt_d  = cnt_inc;
                        commit = (cnt_inc == STABLE_Q);
                    end else begin
                        cand_d = cls;
                        cnt_d  = QCNT_W'(1);
                        commit = ONE_SHOT;
                    end
                end
                ST_LOCKED: begin
                    // Committed mode and mode_valid hold while a new class qualifies.
                    if (cls != mode_q) begin
                        cand_d  = cls;
                        cnt_d   = QCNT_W'(1);
                        commit  = ONE_SHOT;
                        state_d = ST_QUALIFY;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (commit) begin
                state_d   = ST_LOCKED;
                mode_d    = cls;
                valid_d   = 1'b1;
                changed_d = (cls != mode_q) || !valid_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cand_q    <= MODE_STOP;
            cnt_q     <= '0;
            mode_q    <= MODE_STOP;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
        end
    end

    assign bus.motion_mode  = mode_q;
    assign bus.mode_valid   = valid_q;
    assign bus.mode_changed = changed_q;

`ifdef MOTION_CHANGE_CNT_EN
    logic [CHG_CNT_W-1:0] chg_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                  chg_cnt_q <= '0;
        else if (changed_d && (chg_cnt_q != '1))    chg_cnt_q <= chg_cnt_q + CHG_CNT_W'(1);
    end

    assign bus.change_count = chg_cnt_q;
`else
    assign bus.change_count = '0;
`endif

endmodule

// File: tb/tb_motion_mode_encoder.sv
// Directed self-checking bench: STABLE_CNT=3 main instance plus a STABLE_CNT=1 instance, both STALE_CYCLES=10.
module tb_motion_mode_encoder;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

`ifdef MOTION_CHANGE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam int NVEC = 12;
    localparam logic [7:0] CLS_VEC [NVEC] = '{8'h00, 8'h80, 8'h33, 8'hBB, 8'hB3, 8'h3B,
                                              8'hB9, 8'h9B, 8'h0A, 8'hA0, 8'h31, 8'hF7};
    localparam logic [2:0] CLS_EXP [NVEC] = '{3'b000, 3'b000, 3'b110, 3'b101, 3'b010, 3'b100,
                                              3'b001, 3'b011, 3'b011, 3'b001, 3'b011, 3'b010};

    motion_mode_encoder_if bus0();
    motion_mode_encoder_if bus1();

    motion_mode_encoder #(.STABLE_CNT(3), .STALE_CYCLES(26'd10)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    motion_mode_encoder #(.STABLE_CNT(1), .STALE_CYCLES(26'd10)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_count(input int n);
        if (!CNT_EN) return 8'd0;
        return (n > 255) ? 8'd255 : 8'(n);
    endfunction

    // One strobe cycle; returns 1 time unit after the edge that sampled it.
    task automatic send(input logic [7:0] m);
        bus0.motctl = m;      bus1.motctl = m;
        bus0.upd_sysregs = 1'b1; bus1.upd_sysregs = 1'b1;
        @(posedge clk); #1;
        bus0.upd_sysregs = 1'b0; bus1.upd_sysregs = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus0.upd_sysregs = 1'b0; bus1.upd_sysregs = 1'b0;
        bus0.motctl = 8'h00;     bus1.motctl = 8'h00;
        @(posedge clk); #1;
        checks++; if (bus0.motion_mode !== 3'b000) begin errors++; $display("FAIL rst_mode: got %b want 000", bus0.motion_mode); end
        checks++; if (bus0.mode_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus0.mode_valid); end
        checks++; if (bus0.mode_changed !== 1'b0) begin errors++; $display("FAIL rst_changed: got %b want 0", bus0.mode_changed); end
        checks++; if (bus0.change_count !== 8'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", bus0.change_count); end
        checks++; if (bus1.mode_valid !== 1'b0) begin errors++; $display("FAIL rst_valid1: got %b want 0", bus1.mode_valid); end
        reset = 1'b0;
        idle(1);
    endtask

    task automatic test_classify;
        logic exp_pulse;
        for (int i = 0; i < NVEC; i++) begin
            send(CLS_VEC[i]);
            exp_pulse = (i == 0) || (CLS_EXP[i] != CLS_EXP[(i == 0) ? 0 : i-1]);
            checks++; if (bus1.motion_mode !== CLS_EXP[i]) begin errors++; $display("FAIL cls_mode[%0h]: got %b want %b", CLS_VEC[i], bus1.motion_mode, CLS_EXP[i]); end
            checks++; if (bus1.mode_valid !== 1'b1) begin errors++; $display("FAIL cls_valid[%0h]: got %b want 1", CLS_VEC[i], bus1.mode_valid); end
            checks++; if (bus1.mode_changed !== exp_pulse) begin errors++; $display("FAIL cls_changed[%0h]: got %b want %b", CLS_VEC[i], bus1.mode_changed, exp_pulse); end
        end
        checks++; if (bus0.mode_valid !== 1'b0) begin errors++; $display("FAIL cls_main_valid: got %b want 0", bus0.mode_valid); end
    endtask

    task automatic test_forward;
        send(8'hBB);
        checks++; if (bus0.mode_valid !== 1'b0) begin errors++; $display("FAIL fwd_valid1: got %b want 0", bus0.mode_valid); end
        checks++; if (bus1.motion_mode !== 3'b101 || bus1.mode_changed !== 1'b1) begin errors++; $display("FAIL fwd_one_shot: got %b/%b want 101/1", bus1.motion_mode, bus1.mode_changed); end
        send(8'hBB);
        checks++; if (bus0.mode_valid !== 1'b0 || bus0.motion_mode !== 3'b000) begin errors++; $display("FAIL fwd_valid2: got %b/%b want 0/000", bus0.mode_valid, bus0.motion_mode); end
        send(8'hBB);
        checks++; if (bus0.motion_mode !== 3'b101) begin errors++; $display("FAIL fwd_mode: got %b want 101", bus0.motion_mode); end
        checks++; if (bus0.mode_valid !== 1'b1) begin errors++; $display("FAIL fwd_valid3: got %b want 1", bus0.mode_valid); end
        checks++; if (bus0.mode_changed !== 1'b1) begin errors++; $display("FAIL fwd_changed: got %b want 1", bus0.mode_changed); end
        checks++; if (bus0.change_count !== exp_count(1)) begin errors++; $display("FAIL fwd_count: got %0d want %0d", bus0.change_count, exp_count(1)); end
        idle(1);
        checks++; if (bus0.mode_changed !== 1'b0) begin errors++; $display("FAIL fwd_pulse_end: got %b want 0", bus0.mode_changed); end
    endtask

    task automatic test_no_commit;
        logic [7:0] seq [3] = '{8'hB3, 8'hB3, 8'h3B};
        for (int i = 0; i < 3; i++) begin
            send(seq[i]);
            checks++; if (bus0.motion_mode !== 3'b101 || bus0.mode_valid !== 1'b1 || bus0.mode_changed !== 1'b0) begin
                errors++; $display("FAIL hold[%0d]: got %b/%b/%b want 101/1/0", i, bus0.motion_mode, bus0.mode_valid, bus0.mode_changed); end
            if (i == 1) begin
                checks++; if (bus1.motion_mode !== 3'b010 || bus1.mode_changed !== 1'b0) begin errors++; $display("FAIL one_shot_same: got %b/%b want 010/0", bus1.motion_mode, bus1.mode_changed); end
            end
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 3; i++) begin
            send(8'hB3);
            if (i < 2) begin
                checks++; if (bus0.motion_mode !== 3'b101) begin errors++; $display("FAIL r2_hold[%0d]: got %b want 101", i, bus0.motion_mode); end
            end
        end
        checks++; if (bus0.motion_mode !== 3'b010 || bus0.mode_changed !== 1'b1) begin errors++; $display("FAIL r2_commit: got %b/%b want 010/1", bus0.motion_mode, bus0.mode_changed); end
        for (int i = 0; i < 3; i++) begin
            send(8'hB9);
            if (i < 2) begin
                checks++; if (bus0.motion_mode !== 3'b010 || bus0.mode_valid !== 1'b1) begin errors++; $display("FAIL r1_hold[%0d]: got %b/%b want 010/1", i, bus0.motion_mode, bus0.mode_valid); end
            end
        end
        checks++; if (bus0.motion_mode !== 3'b001 || bus0.mode_changed !== 1'b1) begin errors++; $display("FAIL r1_commit: got %b/%b want 001/1", bus0.motion_mode, bus0.mode_changed); end
        checks++; if (bus0.change_count !== exp_count(3)) begin errors++; $display("FAIL b2b_count: got %0d want %0d", bus0.change_count, exp_count(3)); end
    endtask

    task automatic test_stale;
        idle(9);
        checks++; if (bus0.mode_valid !== 1'b1) begin errors++; $display("FAIL stale_early: got %b want 1", bus0.mode_valid); end
        idle(1);
        checks++; if (bus0.mode_valid !== 1'b0 || bus0.motion_mode !== 3'b000) begin errors++; $display("FAIL stale_timeout: got %b/%b want 0/000", bus0.mode_valid, bus0.motion_mode); end
        checks++; if (bus0.mode_changed !== 1'b0) begin errors++; $display("FAIL stale_nopulse: got %b want 0", bus0.mode_changed); end
        checks++; if (bus0.change_count !== exp_count(3)) begin errors++; $display("FAIL stale_count: got %0d want %0d", bus0.change_count, exp_count(3)); end
        repeat (3) send(8'hB9);
        checks++; if (bus0.motion_mode !== 3'b001 || bus0.mode_changed !== 1'b1) begin errors++; $display("FAIL stale_recommit: got %b/%b want 001/1", bus0.motion_mode, bus0.mode_changed); end
        idle(9);
        send(8'hB9);
        checks++; if (bus0.mode_valid !== 1'b1 || bus0.motion_mode !== 3'b001 || bus0.mode_changed !== 1'b0) begin
            errors++; $display("FAIL stale_strobe_wins: got %b/%b/%b want 1/001/0", bus0.mode_valid, bus0.motion_mode, bus0.mode_changed); end
        idle(9);
        checks++; if (bus0.mode_valid !== 1'b1) begin errors++; $display("FAIL stale_restart: got %b want 1", bus0.mode_valid); end
        idle(1);
        checks++; if (bus0.mode_valid !== 1'b0) begin errors++; $display("FAIL stale_timeout2: got %b want 0", bus0.mode_valid); end
    endtask

    task automatic test_reset_midqual;
        repeat (3) send(8'hB9);
        send(8'hBB);
        send(8'hBB);
        checks++; if (bus0.motion_mode !== 3'b001 || bus0.mode_valid !== 1'b1) begin errors++; $display("FAIL mq_hold: got %b/%b want 001/1", bus0.motion_mode, bus0.mode_valid); end
        reset = 1'b1;
        #1;
        checks++; if (bus0.motion_mode !== 3'b000 || bus0.mode_valid !== 1'b0 || bus0.mode_changed !== 1'b0 || bus0.change_count !== 8'd0) begin
            errors++; $display("FAIL mq_async_rst: got %b/%b/%b/%0d want 000/0/0/0", bus0.motion_mode, bus0.mode_valid, bus0.mode_changed, bus0.change_count); end
        @(posedge clk); #1;
        reset = 1'b0;
        send(8'hBB);
        send(8'hBB);
        checks++; if (bus0.mode_valid !== 1'b0) begin errors++; $display("FAIL mq_discard: got %b want 0", bus0.mode_valid); end
        send(8'hBB);
        checks++; if (bus0.motion_mode !== 3'b101 || bus0.mode_valid !== 1'b1 || bus0.mode_changed !== 1'b1) begin
            errors++; $display("FAIL mq_commit: got %b/%b/%b want 101/1/1", bus0.motion_mode, bus0.mode_valid, bus0.mode_changed); end
        checks++; if (bus0.change_count !== exp_count(1)) begin errors++; $display("FAIL mq_count: got %0d want %0d", bus0.change_count, exp_count(1)); end
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 300; i++) begin
            repeat (3) send((i % 2 == 0) ? 8'hB3 : 8'hBB);
            if (i == 252) begin
                checks++; if (bus0.change_count !== exp_count(254)) begin errors++; $display("FAIL sat_pre: got %0d want %0d", bus0.change_count, exp_count(254)); end
            end
        end
        checks++; if (bus0.change_count !== exp_count(301)) begin errors++; $display("FAIL sat_count: got %0d want %0d", bus0.change_count, exp_count(301)); end
        checks++; if (bus0.motion_mode !== 3'b101 || bus0.mode_changed !== 1'b1) begin errors++; $display("FAIL sat_last: got %b/%b want 101/1", bus0.motion_mode, bus0.mode_changed); end
    endtask

    initial begin
        bus0.motctl = 8'h00;  bus1.motctl = 8'h00;
        bus0.upd_sysregs = 1'b0; bus1.upd_sysregs = 1'b0;
        test_reset();
        test_classify();
        test_reset();
        test_forward();
        test_no_commit();
        test_back_to_back();
        test_stale();
        test_reset_midqual();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
